// File: rtl/layer_priority_sequencer.sv
// layer_priority_sequencer
// Per-pixel sprite-layer compositor feeding the 4-bit palette decoder.
// - Each pixel takes one palette index from the flame, copter, smoke or
//   background layer, chosen by a fixed priority.
// - A frame-synchronous crash sequencer (IDLE -> FLASH -> SMOKE -> DONE)
//   changes that priority, suppresses layers, or forces the flash colour.
// - Index 4'h0 on a sprite layer means transparent.
//
// Pixel strobe semantics:
// - The two-stage pipeline moves only on Clk edges where pixel_en is high.
// - While pixel_en is low, every pipeline register and both outputs hold.
// - A pixel presented with pixel_en high appears on pal_idx/pal_valid
//   exactly two strobes later.
// - The crash sequencer ignores pixel_en. It reacts only to frame_start
//   and restart.
// - crash_state is the sequencer state register itself, so the FSM can be
//   observed directly.

module layer_priority_sequencer #(
    parameter int FLASH_FRAMES = 8,
    parameter int SMOKE_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pixel_en,
    input  logic       frame_start,
    input  logic       active_video,
    input  logic       copter_hit,
    input  logic       flame_hit,
    input  logic       smoke_hit,
    input  logic [3:0] copter_idx,
    input  logic [3:0] flame_idx,
    input  logic [3:0] smoke_idx,
    input  logic [3:0] bg_idx,
    input  logic       crash,
    input  logic       restart,
    output logic [3:0] pal_idx,
    output logic       pal_valid,
    output logic [1:0] crash_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLASH = 2'b01,
        ST_SMOKE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] SMOKE_LAST = 8'(SMOKE_FRAMES - 1);
    localparam logic [3:0] FLASH_COLOUR = 4'hF;

    state_e     state_q;
    logic [7:0] frame_cnt_q;
    logic       crash_pend_q;

    // Stage-1 copies of the layer inputs
    logic       s1_active_q;
    logic       s1_copter_hit_q;
    logic       s1_flame_hit_q;
    logic       s1_smoke_hit_q;
    logic [3:0] s1_copter_idx_q;
    logic [3:0] s1_flame_idx_q;
    logic [3:0] s1_smoke_idx_q;
    logic [3:0] s1_bg_idx_q;

    // Stage-2 output registers
    logic [3:0] pal_idx_q;
    logic       pal_valid_q;
    logic [3:0] pal_idx_d;
    logic       pal_valid_d;

    logic copter_ok;
    logic flame_ok;
    logic smoke_ok;

    // Crash sequencer.
    // - restart beats everything else in the same cycle.
    // - State moves only on frame_start (or restart).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= 8'd0;
            crash_pend_q <= 1'b0;
        end else if (restart) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= 8'd0;
            crash_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start && (crash_pend_q || crash)) begin
                        state_q      <= ST_FLASH;
                        frame_cnt_q  <= 8'd0;
                        crash_pend_q <= 1'b0;
                    end else if (crash) begin
                        crash_pend_q <= 1'b1;
                    end
                end
                ST_FLASH: begin
                    if (frame_start) begin
                        if (frame_cnt_q == FLASH_LAST) begin
                            state_q     <= ST_SMOKE;
                            frame_cnt_q <= 8'd0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end
                ST_SMOKE: begin
                    if (frame_start) begin
                        if (frame_cnt_q == SMOKE_LAST) begin
                            state_q     <= ST_DONE;
                            frame_cnt_q <= 8'd0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    // DONE holds until restart
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

    // Stage 1: capture the layer inputs on each pixel strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_active_q     <= 1'b0;
            s1_copter_hit_q <= 1'b0;
            s1_flame_hit_q  <= 1'b0;
            s1_smoke_hit_q  <= 1'b0;
            s1_copter_idx_q <= 4'h0;
            s1_flame_idx_q  <= 4'h0;
            s1_smoke_idx_q  <= 4'h0;
            s1_bg_idx_q     <= 4'h0;
        end else if (pixel_en) begin
            s1_active_q     <= active_video;
            s1_copter_hit_q <= copter_hit;
            s1_flame_hit_q  <= flame_hit;
            s1_smoke_hit_q  <= smoke_hit;
            s1_copter_idx_q <= copter_idx;
            s1_flame_idx_q  <= flame_idx;
            s1_smoke_idx_q  <= smoke_idx;
            s1_bg_idx_q     <= bg_idx;
        end
    end

    // Eligibility: a sprite layer counts only if it covers the pixel and is not transparent
    assign copter_ok = s1_copter_hit_q && (s1_copter_idx_q != 4'h0);
    assign flame_ok  = s1_flame_hit_q  && (s1_flame_idx_q  != 4'h0);
    assign smoke_ok  = s1_smoke_hit_q  && (s1_smoke_idx_q  != 4'h0);

    // Priority select for the stage-1 pixel under the current crash state
    always_comb begin
        pal_idx_d   = 4'h0;
        pal_valid_d = 1'b0;
        if (s1_active_q) begin
            pal_valid_d = 1'b1;
            case (state_q)
                ST_FLASH: begin
                    if (!frame_cnt_q[0]) begin
                        pal_idx_d = FLASH_COLOUR;
                    end else if (flame_ok) begin
                        pal_idx_d = s1_flame_idx_q;
                    end else if (copter_ok) begin
                        pal_idx_d = s1_copter_idx_q;
                    end else if (smoke_ok) begin
                        pal_idx_d = s1_smoke_idx_q;
                    end else begin
                        pal_idx_d = s1_bg_idx_q;
                    end
                end
                ST_SMOKE: begin
                    if (smoke_ok) begin
                        pal_idx_d = s1_smoke_idx_q;
                    end else if (flame_ok) begin
                        pal_idx_d = s1_flame_idx_q;
                    end else begin
                        pal_idx_d = s1_bg_idx_q;
                    end
                end
                ST_DONE: begin
                    pal_idx_d = s1_bg_idx_q;
                end
                default: begin
                    if (flame_ok) begin
                        pal_idx_d = s1_flame_idx_q;
                    end else if (copter_ok) begin
                        pal_idx_d = s1_copter_idx_q;
                    end else if (smoke_ok) begin
                        pal_idx_d = s1_smoke_idx_q;
                    end else begin
                        pal_idx_d = s1_bg_idx_q;
                    end
                end
            endcase
        end
    end

    // Stage 2: register the selected index on each pixel strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_idx_q   <= 4'h0;
            pal_valid_q <= 1'b0;
        end else if (pixel_en) begin
            pal_idx_q   <= pal_idx_d;
            pal_valid_q <= pal_valid_d;
        end
    end

    assign pal_idx     = pal_idx_q;
    assign pal_valid   = pal_valid_q;
    assign crash_state = state_q;

endmodule

// File: tb/tb_layer_priority_sequencer.sv
// Bench for layer_priority_sequencer (FLASH_FRAMES=4, SMOKE_FRAMES=2).
// Each pixel pushes its expected {pal_valid, pal_idx} into a queue.
// Every pixel strobe pops the entry for the pixel two strobes back.

module tb_layer_priority_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       pixel_en;
  logic       frame_start;
  logic       active_video;
  logic       copter_hit, flame_hit, smoke_hit;
  logic [3:0] copter_idx, flame_idx, smoke_idx, bg_idx;
  logic       crash;
  logic       restart;
  logic [3:0] pal_idx;
  logic       pal_valid;
  logic [1:0] crash_state;

  logic [4:0] exp_q[$];
  int         n_cmp;
  int         n_mis;
  logic [1:0] m_st;
  logic       m_odd;

  layer_priority_sequencer #(
    .FLASH_FRAMES(4),
    .SMOKE_FRAMES(2)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pixel_en     (pixel_en),
    .frame_start  (frame_start),
    .active_video (active_video),
    .copter_hit   (copter_hit),
    .flame_hit    (flame_hit),
    .smoke_hit    (smoke_hit),
    .copter_idx   (copter_idx),
    .flame_idx    (flame_idx),
    .smoke_idx    (smoke_idx),
    .bg_idx       (bg_idx),
    .crash        (crash),
    .restart      (restart),
    .pal_idx      (pal_idx),
    .pal_valid    (pal_valid),
    .crash_state  (crash_state)
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected {valid, idx} for one pixel, given the sequencer mode it is composited in
  function automatic logic [4:0] model(input logic av, input logic fh, input logic [3:0] fi,
                                       input logic ch, input logic [3:0] ci,
                                       input logic sh, input logic [3:0] si,
                                       input logic [3:0] bi, input logic [1:0] st,
                                       input logic odd);
    logic f, c, s;
    f = fh && (fi != 4'h0);
    c = ch && (ci != 4'h0);
    s = sh && (si != 4'h0);
    if (!av) return 5'h00;
    if (st == 2'b01 && !odd) return {1'b1, 4'hF};
    if (st == 2'b00 || st == 2'b01) begin
      if (f) return {1'b1, fi};
      if (c) return {1'b1, ci};
      if (s) return {1'b1, si};
      return {1'b1, bi};
    end
    if (st == 2'b10) begin
      if (s) return {1'b1, si};
      if (f) return {1'b1, fi};
      return {1'b1, bi};
    end
    return {1'b1, bi};
  endfunction

  // driver: present one pixel for one strobe, then score the output
  task automatic pix(input string tag, input logic av, input logic fh, input logic [3:0] fi,
                     input logic ch, input logic [3:0] ci, input logic sh, input logic [3:0] si,
                     input logic [3:0] bi);
    logic [4:0] e;
    @(negedge Clk);
    active_video = av;
    flame_hit = fh;  flame_idx = fi;
    copter_hit = ch; copter_idx = ci;
    smoke_hit = sh;  smoke_idx = si;
    bg_idx = bi;
    pixel_en = 1'b1;
    exp_q.push_back(model(av, fh, fi, ch, ci, sh, si, bi, m_st, m_odd));
    @(negedge Clk);
    pixel_en = 1'b0;
    e = 5'h1F;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, {3'b000, pal_valid, pal_idx}, {3'b000, e});
  endtask

  // driver: blank pixel to drain, then one control cycle, then check the state
  task automatic ctl(input string tag, input logic fs, input logic cr, input logic rs,
                     input logic [1:0] est, input logic eodd);
    pix({tag, "_blank"}, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    @(negedge Clk);
    frame_start = fs; crash = cr; restart = rs;
    @(negedge Clk);
    frame_start = 1'b0; crash = 1'b0; restart = 1'b0;
    chk(tag, {6'b0, crash_state}, {6'b0, est});
    m_st = est;
    m_odd = eodd;
  endtask

  // driver: asynchronous reset between clock edges
  task automatic do_reset(input string tag);
    @(negedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk({tag, "_idx"},   {4'h0, pal_idx},            8'h00);
    chk({tag, "_valid"}, {7'h0, pal_valid},          8'h00);
    chk({tag, "_state"}, {6'h0, crash_state},        8'h00);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(5'h00);
    m_st = 2'b00;
    m_odd = 1'b0;
    chk({tag, "_post_state"}, {6'h0, crash_state}, 8'h00);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    m_st = 2'b00; m_odd = 1'b0;
    Reset_n = 1'b0;
    pixel_en = 0; frame_start = 0; active_video = 0;
    copter_hit = 0; flame_hit = 0; smoke_hit = 0;
    copter_idx = 0; flame_idx = 0; smoke_idx = 0; bg_idx = 0;
    crash = 0; restart = 0;
    exp_q.push_back(5'h00);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // some traffic, then reset mid-stream
    for (int i = 0; i < 3; i++)
      pix("pre", 1'b1, 1'b0, 4'h0, 1'b1, 4'(i + 1), 1'b0, 4'h0, 4'h2);
    do_reset("rst1");

    // flame over copter, latency 2 strobes
    for (int i = 0; i < 4; i++)
      pix("flame_win", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    // transparent flame falls through to copter
    for (int i = 0; i < 4; i++)
      pix("copter_win", 1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    pix("smoke_idle", 1'b1, 1'b0, 4'h8, 1'b1, 4'h0, 1'b1, 4'h3, 4'h2);
    pix("bg_zero",    1'b1, 1'b0, 4'h0, 1'b0, 4'h5, 1'b0, 4'h0, 4'h0);
    pix("bg_pick",    1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'hC, 4'h9);
    pix("pre_blank",  1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h1);

    // blanking pixel, then hold pixel_en low for 10 clocks
    pix("blank", 1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 4'h0, 4'h2);
    repeat (10) @(negedge Clk);
    chk("hold", {3'b000, pal_valid, pal_idx}, {3'b000, 1'b1, 4'h4});
    pix("blank_out", 1'b1, 1'b0, 4'h0, 1'b1, 4'h6, 1'b0, 4'h0, 4'h2);

    // crash mid-frame waits for frame_start
    @(negedge Clk); crash = 1'b1;
    @(negedge Clk); crash = 1'b0;
    repeat (3) @(negedge Clk);
    chk("crash_wait", {6'h0, crash_state}, 8'h00);
    pix("crash_idle", 1'b1, 1'b1, 4'h7, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    ctl("crash_latched", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    ctl("restart1", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    pix("idle_again", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    ctl("crash_same", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);

    // FLASH frame 0..3
    pix("fl0_a", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);
    pix("fl0_b", 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h2);
    pix("fl0_c", 1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 4'h0, 4'h2);
    ctl("fl1", 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    pix("fl1_a", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);
    pix("fl1_b", 1'b1, 1'b0, 4'h8, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    ctl("fl2", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    pix("fl2_a", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);
    ctl("fl3", 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    pix("fl3_a", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);

    // SMOKE for two frames
    ctl("sm0", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    pix("sm0_smoke",  1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);
    pix("sm0_copter", 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    pix("sm0_flame",  1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'h0, 4'h2);
    ctl("sm1", 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    pix("sm1_smoke",  1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h3);

    // DONE: background only, crash ignored
    ctl("done", 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
    pix("done_bg",  1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);
    pix("done_bg0", 1'b1, 1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    ctl("done_hold", 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);

    // restart in SMOKE with frame_start and crash together
    ctl("restart2", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    ctl("crash2", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    ctl("fl1b", 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    ctl("fl2b", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    ctl("fl3b", 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    ctl("sm0b", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    ctl("rst_prio", 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
    ctl("no_reentry", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    pix("idle_after", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b1, 4'hE, 4'h2);

    // async reset during FLASH between strobes
    ctl("crash3", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    pix("fl_pre_a", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    pix("fl_pre_b", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    do_reset("rst2");
    pix("post_a", 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    pix("post_b", 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h2);
    pix("post_c", 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/layer_priority_sequencer.md
# layer_priority_sequencer

Per-pixel compositor and crash-sequence controller in front of the 4-bit palette decoder. It selects one palette index per pixel from the copter, flame, smoke and background sprite layers by fixed priority, with index 4'h0 meaning transparent. A frame-synchronous crash state machine reorders or suppresses layers and forces the flash colour. The block registers the selected index through a 2-stage, pixel-enable-gated pipeline and drives it to the palette.

## Interface
Parameters:
- FLASH_FRAMES, 8, number of frames spent in FLASH (legal 1..255)
- SMOKE_FRAMES, 60, number of frames spent in SMOKE (legal 1..255)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- pixel_en  in  1  pixel strobe; pipeline advances only when high
- frame_start  in  1  one-Clk pulse at start of vertical blank
- active_video  in  1  high while the current pixel is visible
- copter_hit, flame_hit, smoke_hit  in  1 each  layer covers the current pixel
- copter_idx, flame_idx, smoke_idx, bg_idx  in  4 each  layer palette index
- crash  in  1  one-Clk crash event pulse
- restart  in  1  one-Clk pulse returning to normal play
- pal_idx  out  4  index to the palette decoder
- pal_valid  out  1  pal_idx belongs to a visible pixel
- crash_state  out  2  00 IDLE, 01 FLASH, 10 SMOKE, 11 DONE

## Operation
- A layer is eligible when its hit=1 and its idx≠4'h0. The background is always eligible, including bg_idx=0.
- Priority by state:
  - IDLE: flame > copter > smoke > bg.
  - FLASH: same as IDLE on odd frames (frame_cnt[0]=1). On even frames, every visible pixel is 4'hF.
  - SMOKE: smoke > flame > bg. The copter is suppressed.
  - DONE: bg only.
- When active_video=0 at stage 1, pal_idx=4'h0 and pal_valid=0.
- Crash capture:
  - A crash pulse in IDLE sets crash_pend.
  - At frame_start with crash_pend=1 (or crash=1 in the same cycle): IDLE→FLASH, frame_cnt←0, crash_pend←0.
  - crash outside IDLE is ignored and not latched.
- FLASH: each frame_start increments frame_cnt (8-bit). At a frame_start with frame_cnt=FLASH_FRAMES-1: →SMOKE, frame_cnt←0.
- SMOKE: same rule with SMOKE_FRAMES-1, →DONE.
- DONE: holds until restart.
- restart in any state: →IDLE on the next Clk edge, frame_cnt←0, crash_pend←0.
  - restart has priority over crash and frame_start in the same cycle.
- State and frame_cnt change only on frame_start or restart, never mid-line from compositing.

## Timing
- Reset (Reset_n=0, asynchronous): pal_idx=4'h0, pal_valid=0, crash_state=00, frame_cnt=0, crash_pend=0, pipeline registers=0. Reset applied mid-frame or mid-sequence takes effect immediately. The first pixel after release is composited in IDLE.
- Pipeline, advancing only on Clk edges with pixel_en=1:
  - Stage 1 registers all layer inputs and active_video.
  - Stage 2 registers pal_idx/pal_valid computed from the stage-1 data and the current crash_state.
  - Latency is exactly 2 pixel_en strobes. Outputs hold while pixel_en=0.
- crash_state updates on the Clk edge of the triggering frame_start/restart cycle, independent of pixel_en.
- frame_start and pixel_en may coincide. Both take effect on the same edge.

## Test plan
- Reset mid-stream, then 4 pixels with flame_hit=1/flame_idx=8, copter_hit=1/copter_idx=4, bg_idx=2 → pal_idx=4'h8 starting exactly 2 pixel_en strobes after the first, pal_valid=1. Repeat with flame_idx=0 → pal_idx=4'h4.
- active_video=0 with copter_hit=1, copter_idx=5 → pal_idx=0, pal_valid=0. With pixel_en held low for 10 Clk → outputs unchanged.
- crash pulse mid-frame → crash_state stays 00 until the next frame_start, then 01. Check crash and frame_start in the same cycle → 01 on that edge.
- FLASH_FRAMES=4, SMOKE_FRAMES=2 → FLASH frames 0 and 2 output 4'hF on all visible pixels, frames 1 and 3 output the normal composite. SMOKE lasts 2 frames with copter suppressed and smoke_idx=14 winning over flame_idx=8. Then DONE shows bg_idx only.
- restart asserted in SMOKE together with frame_start and crash → crash_state=00 next edge, no re-entry to FLASH on the following frame_start.
- Reset_n pulsed low during FLASH between pixel_en strobes → all outputs 0 immediately. crash_state=00 after release.
